inst_mem_responder: RTL and testbench
=====================================

// Module: inst_mem_responder
// PURPOSE
//   Instruction-memory responder: the far end of the fetch interface. Takes the
//   PC on i_inst_addr, returns the instruction word on i_inst_rdata after a fixed
//   pipelined latency, and honours the decode-stage stall.
//   Also provides a sequential program-load port used by the bench/boot loader.
//   Sits between the fetch stage and the instruction RAM, outside the CPU core.
// PARAMETERS
//   DEPTH  4096          instruction words stored; power of two
//   BASE   32'h0000_3000 byte address of word 0
//   LAT    1             request-to-response latency in cycles; legal 1..4
// PORTS
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-LOW reset
//   req_valid    in   1   fetch request present on i_inst_addr
//   i_inst_addr  in   32  byte address of the instruction
//   hold         in   1   stall (D_stall): freeze the response pipeline
//   i_inst_rdata out  32  instruction word
//   rsp_valid    out  1   i_inst_rdata and rsp_err are valid this cycle
//   rsp_err      out  1   responded address was misaligned or out of range
//   busy         out  1   program load in progress; requests are ignored
//   load_start   in   1   pulse: enter LOAD state, write pointer := 0
//   load_we      in   1   write load_data at the pointer; pointer++
//   load_data    in   32  program word
//   load_last    in   1   with load_we: final word; return to IDLE
//   load_ptr     out  AW  current write pointer, AW = log2(DEPTH)
// BEHAVIOUR
//   Reset (reset=0, async): i_inst_rdata=0, rsp_valid=0, rsp_err=0, busy=0,
//     load_ptr=0, FSM=IDLE, response pipeline flushed. RAM contents are kept.
//   FSM: IDLE --load_start--> LOAD. In LOAD, a cycle with load_we=1 writes RAM[ptr]
//     and increments ptr. ptr wraps DEPTH-1 -> 0. In LOAD, load_we & load_last
//     --> IDLE at the next edge. load_start while in LOAD restarts with ptr=0.
//     busy=1 exactly while FSM=LOAD; this output is registered.
//   Accept: at a rising edge with req_valid=1, busy=0 and hold=0.
//     Requests under busy=1 or hold=1 are dropped and produce no response.
//     load_start in the same cycle as a request: the load wins; the request is dropped.
//   Index: idx = (i_inst_addr - BASE) >> 2, 32-bit unsigned subtraction.
//     err = (addr[1:0] != 0) | (addr < BASE) | (idx >= DEPTH).
//     When err=1, the data returned is 32'h0000_0000.
//   Latency: an accepted request yields rsp_valid=1 exactly LAT non-hold edges later.
//     Back-to-back accepts give back-to-back responses (throughput 1/cycle).
//   hold=1: every pipeline stage and every output keeps its value; no new accept.
//     A response already valid stays asserted and unchanged until hold drops.
//   rsp_valid deasserts the cycle after the response if no request follows.
//     i_inst_rdata keeps its last value when rsp_valid=0.
//   Read/write collision (load write to an idx being read): cannot occur,
//     because reads are blocked in LOAD; data loaded before load_last is visible
//     to the first request accepted in IDLE.
//   Reset mid-load: FSM=IDLE, busy=0, ptr=0; words already written are retained.
//   Reset mid-read: in-flight responses are discarded; rsp_valid=0.
// TESTING
//   1. load_start; load_we with 32'h3C01_1234, 32'h3421_0001, the second with
//      load_last -> load_ptr=2; busy falls 1 cycle after the last word.
//   2. LAT=1: req 0x3000 then 0x3004 on consecutive cycles -> rsp_valid 2 cycles,
//      rdata 3C011234 then 34210001, rsp_err=0.
//   3. Addresses 0x3002, 0x2FFC, 0x3000+4*DEPTH -> rsp_err=1, rdata=0 for each.
//   4. hold=1 for 3 cycles while rdata=3C011234 is valid -> value and rsp_valid
//      unchanged; next response only after hold=0; no request lost or duplicated.
//   5. req_valid during busy=1 -> no rsp_valid; reset=0 at load_ptr=5 ->
//      busy=0, load_ptr=0, words 0..4 still readable.
//   6. LAT=3 streaming 8 sequential addresses -> 8 responses in order, first
//      response 3 cycles after the first accept.

Source files
------------

// File: rtl/inst_mem_responder.sv
// inst_mem_responder
//   Far end of the instruction-fetch interface. A request carries a byte PC on
//   i_inst_addr. The word is returned on i_inst_rdata through a LAT-stage
//   response pipeline. The decode-stage stall (hold) freezes that pipeline.
//   A sequential load port writes program words into the RAM. It is used by
//   the boot loader or a test bench.
//
// Ports
//   clk, reset                 rising-edge clock, async active-low reset
//   req_valid, i_inst_addr     fetch request and its byte address
//   hold                       freeze the response pipeline and block accepts
//   i_inst_rdata, rsp_valid    response word and its qualifier
//   rsp_err                    responded address was misaligned or out of range
//   busy                       program load in progress (requests dropped)
//   load_start                 enter LOAD with the write pointer at 0
//   load_we, load_data         write one word at the pointer, then advance
//   load_last                  with load_we: final word, return to IDLE
//   load_ptr                   current write pointer
//
// Timing: a request sampled at edge N reads the RAM and enters stage 0.
// With LAT=1 it is visible right after edge N, i.e. sampled valid at edge N+1.
// Each extra stage adds one non-hold edge.
module inst_mem_responder #(
  parameter int unsigned DEPTH = 4096,
  parameter logic [31:0] BASE  = 32'h0000_3000,
  parameter int unsigned LAT   = 1,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [31:0]   i_inst_addr,
  input  logic          hold,
  output logic [31:0]   i_inst_rdata,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic          busy,
  input  logic          load_start,
  input  logic          load_we,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic [AW-1:0] load_ptr
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StLoad = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          mem_we;

  logic [31:0]   mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Load FSM. load_start takes priority over a write in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_we  = 1'b0;
    if (load_start) begin
      state_d = StLoad;
      ptr_d   = '0;
    end else if (state_q == StLoad && load_we) begin
      mem_we = 1'b1;
      ptr_d  = ptr_q + 1'b1;  // DEPTH is a power of two, so this wraps naturally
      if (load_last) begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy     = (state_q == StLoad);
  assign load_ptr = ptr_q;

  // RAM is deliberately not reset so program contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr_q] <= load_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Request decode. BASE is word aligned, so the word offset can be taken
  // directly from the upper address bits.
  // ---------------------------------------------------------------------------
  logic [29:0]   diff_w;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          req_err;
  logic          accept;
  logic [31:0]   rd_data;

  assign diff_w   = i_inst_addr[31:2] - BASE[31:2];
  assign idx      = diff_w[AW-1:0];
  assign in_range = (diff_w[29:AW] == '0);
  assign req_err  = (|i_inst_addr[1:0]) | (i_inst_addr < BASE) | ~in_range;
  // A load_start in the same cycle wins over the request.
  assign accept   = req_valid & ~busy & ~hold & ~load_start;
  assign rd_data  = req_err ? 32'h0000_0000 : mem[idx];

  // ---------------------------------------------------------------------------
  // Response pipeline. Data and error fields only move along with a valid
  // token, so the output word holds its last value when rsp_valid is low.
  // ---------------------------------------------------------------------------
  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] err_q;
  logic [31:0]    dat_q [LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      err_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else if (!hold) begin
      vld_q[0] <= accept;
      if (accept) begin
        dat_q[0] <= rd_data;
        err_q[0] <= req_err;
      end
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
          err_q[i] <= err_q[i-1];
        end
      end
    end
  end

  assign rsp_valid    = vld_q[LAT-1];
  assign rsp_err      = err_q[LAT-1];
  assign i_inst_rdata = dat_q[LAT-1];

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder. Two instances, with LAT=1 and LAT=3, share
// one stimulus stream.
// The reference model keeps a word array for the RAM and a queue of accepted
// requests per instance. Each entry is due a fixed number of non-stalled edges
// after its accept.
module tb_inst_mem_responder;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] i_inst_addr = '0;
  logic        hold = 1'b0;
  logic        load_start = 1'b0;
  logic        load_we = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;

  logic [31:0] rdata1, rdata3;
  logic        rv1, rv3, re1, re3, busy1, busy3;
  logic [11:0] ptr1, ptr3;

  always #5 clk = ~clk;

  inst_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .i_inst_addr(i_inst_addr),
    .hold(hold), .i_inst_rdata(rdata1), .rsp_valid(rv1), .rsp_err(re1),
    .busy(busy1), .load_start(load_start), .load_we(load_we),
    .load_data(load_data), .load_last(load_last), .load_ptr(ptr1)
  );

  inst_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .i_inst_addr(i_inst_addr),
    .hold(hold), .i_inst_rdata(rdata3), .rsp_valid(rv3), .rsp_err(re3),
    .busy(busy3), .load_start(load_start), .load_we(load_we),
    .load_data(load_data), .load_last(load_last), .load_ptr(ptr3)
  );

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t        q1[$];
  rsp_t        q3[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] nh = '0;
  logic        m_busy = 1'b0;
  int unsigned m_ptr = 0;
  logic        c1_v = 1'b0, c1_e = 1'b0, c3_v = 1'b0, c3_e = 1'b0;
  logic [31:0] c1_d = '0, c3_d = '0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t lookup(input logic [31:0] a, input logic [31:0] due);
    rsp_t        r;
    logic [31:0] off;
    off    = a - BASE;
    r.due  = due;
    r.err  = (a[1:0] != 2'b00) || (a < BASE) || ((off >> 2) >= DEPTH);
    r.data = 32'h0;
    if (!r.err) r.data = ref_mem[int'(off >> 2)];
    return r;
  endfunction

  task automatic check_outputs();
    chk("rsp_valid_lat1", 32'(rv1), 32'(c1_v));
    chk("rdata_lat1", rdata1, c1_d);
    if (c1_v) chk("rsp_err_lat1", 32'(re1), 32'(c1_e));
    chk("rsp_valid_lat3", 32'(rv3), 32'(c3_v));
    chk("rdata_lat3", rdata3, c3_d);
    if (c3_v) chk("rsp_err_lat3", 32'(re3), 32'(c3_e));
    chk("busy", 32'(busy1), 32'(m_busy));
    chk("busy_lat3", 32'(busy3), 32'(m_busy));
    chk("load_ptr", 32'(ptr1), m_ptr);
  endtask

  // One clock: update the model from the inputs seen at the edge, then check.
  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = req_valid && !m_busy && !hold && !load_start;
    if (!hold) nh++;
    if (acc) begin
      q1.push_back(lookup(i_inst_addr, nh));
      q3.push_back(lookup(i_inst_addr, nh + 32'd2));
    end
    if (load_start) begin
      m_busy = 1'b1;
      m_ptr  = 0;
    end else if (m_busy && load_we) begin
      ref_mem[m_ptr] = load_data;
      m_ptr = (m_ptr + 1) % DEPTH;
      if (load_last) m_busy = 1'b0;
    end
    if (!hold) begin
      c1_v = 1'b0;
      if (q1.size() > 0 && q1[0].due == nh) begin
        c1_v = 1'b1; c1_d = q1[0].data; c1_e = q1[0].err; void'(q1.pop_front());
      end
      c3_v = 1'b0;
      if (q3.size() > 0 && q3[0].due == nh) begin
        c3_v = 1'b1; c3_d = q3[0].data; c3_e = q3[0].err; void'(q3.pop_front());
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    q1.delete();
    q3.delete();
    c1_v = 1'b0; c1_e = 1'b0; c1_d = '0;
    c3_v = 1'b0; c3_e = 1'b0; c3_d = '0;
    m_busy = 1'b0;
    m_ptr  = 0;
    check_outputs();
    #1;
    reset = 1'b1;
  endtask

  task automatic req(input logic [31:0] a);
    req_valid   = 1'b1;
    i_inst_addr = a;
    tick();
    req_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int unsigned r;
    // Reset values
    #7;
    check_outputs();
    reset = 1'b1;

    // Short program load
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_we = 1'b1; load_data = 32'h3C01_1234; tick();
    load_data = 32'h3421_0001; load_last = 1'b1; tick();
    load_we = 1'b0; load_last = 1'b0;
    chk("load2_ptr", 32'(ptr1), 32'd2);
    chk("load2_busy_low", 32'(busy1), 32'd0);

    // Back-to-back reads
    req(32'h3000); req(32'h3004);
    idle(4);

    // Error addresses
    req(32'h3002); req(32'h2FFC); req(BASE + 4 * DEPTH); req(32'hFFFF_FFFC);
    idle(4);

    // Stall while a response is valid; the held request must be served once
    req(32'h3000);
    hold = 1'b1; req_valid = 1'b1; i_inst_addr = 32'h3004;
    idle(3);
    chk("hold_rdata", rdata1, 32'h3C01_1234);
    hold = 1'b0; tick(); req_valid = 1'b0;
    idle(4);

    // Full load with pointer wrap, then a final word at index 0
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_we = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      load_data = $urandom;
      tick();
    end
    chk("wrap_ptr", 32'(ptr1), 32'd0);
    load_data = $urandom; load_last = 1'b1; tick();
    load_we = 1'b0; load_last = 1'b0;

    // Requests under busy are dropped; reset mid-load keeps written words
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_data = $urandom;
      tick();
    end
    load_we = 1'b0;
    req_valid = 1'b1; i_inst_addr = 32'h3000;
    idle(2);
    req_valid = 1'b0;
    chk("midload_ptr", 32'(ptr1), 32'd5);
    do_reset();
    for (int i = 0; i < 5; i++) req(BASE + 32'(4 * i));
    idle(4);

    // Streaming 8 sequential words
    for (int i = 0; i < 8; i++) req(BASE + 32'h20 + 32'(4 * i));
    idle(5);

    // Random traffic with stalls, error addresses and a reset mid-read
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(3) != 0);
      hold      = ($urandom_range(4) == 0);
      r = $urandom_range(7);
      if (r <= 4)      i_inst_addr = BASE + 4 * $urandom_range(DEPTH - 1);
      else if (r == 5) i_inst_addr = (BASE + $urandom_range(4 * DEPTH - 1)) | 32'h1;
      else if (r == 6) i_inst_addr = $urandom_range(BASE - 1);
      else             i_inst_addr = BASE + 4 * DEPTH + 4 * $urandom_range(1023);
      tick();
      if (c == 200) do_reset();
    end
    req_valid = 1'b0; hold = 1'b0;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
